// File: rtl/dem_dsm_quantizer.sv
// dem_dsm_quantizer: second-order error-feedback delta-sigma requantizer
// feeding the DEM switching tree, with an aligned pseudorandom bit.
module dem_dsm_quantizer #(
   parameter int          IN_WIDTH  = 12,
   parameter int          WIDTH     = 4,
   parameter logic [14:0] LFSR_SEED = 15'h0001
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                sample_valid_i,
   input  logic [IN_WIDTH-1:0] din_i,
   input  logic                clear_ovl_i,
   output logic [WIDTH-1:0]    quantized_value_o,
   output logic                pn_seq_o,
   output logic                q_valid_o,
   output logic                overload_o
);
   localparam int SHIFT = IN_WIDTH - WIDTH;
   localparam int AW = IN_WIDTH + 3;
   localparam logic [14:0] SEED = (LFSR_SEED == 15'h0000) ? 15'h0001 : LFSR_SEED;
   localparam logic signed [AW-1:0] Q_MAX = AW'((1 << WIDTH) - 1);
   logic signed [AW-1:0] e1, e2, u, q_raw, e;
   logic [WIDTH-1:0] q;
   logic [14:0] lfsr;
   logic clamp_hi, clamp_lo, clamp, fb;
   always_comb begin
      u = $signed({3'b000, din_i}) + (e1 <<< 1) - e2;
      q_raw = u >>> SHIFT;
      clamp_hi = q_raw > Q_MAX;
      clamp_lo = q_raw[AW-1];
      clamp = clamp_hi || clamp_lo;
      q = clamp_lo ? '0 : clamp_hi ? '1 : q_raw[WIDTH-1:0];
      e = u - (q_raw <<< SHIFT);
      fb = lfsr[14] ^ lfsr[13];
   end
   // a clamp wipes both error taps so the loop cannot stay saturated
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         quantized_value_o <= '0;
         pn_seq_o <= 1'b0;
         q_valid_o <= 1'b0;
         overload_o <= 1'b0;
         e1 <= '0;
         e2 <= '0;
         lfsr <= SEED;
      end else begin
         if (sample_valid_i) begin
            quantized_value_o <= q;
            pn_seq_o <= fb;
            lfsr <= {lfsr[13:0], fb};
            e1 <= clamp ? '0 : e;
            e2 <= clamp ? '0 : e1;
         end
         q_valid_o <= sample_valid_i;
         overload_o <= (sample_valid_i && clamp) || (overload_o && !clear_ovl_i);
      end
   end
endmodule

// File: tb/tb_dem_dsm_quantizer.sv
// tb_dem_dsm_quantizer: directed and random checks of the delta-sigma quantizer
// against an integer reference model.
module tb_dem_dsm_quantizer;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic valid = 1'b0;
   logic [11:0] din = '0;
   logic clr = 1'b0;
   logic [3:0] q_out;
   logic pn_out, qv_out, ovl_out;
   int n_cmp = 0;
   int n_err = 0;
   int me1, me2, mq, mpn, mvld, movl, mlfsr;
   int hist[64];

   dem_dsm_quantizer dut (
      .clk_i(clk), .reset_i(reset_n), .sample_valid_i(valid), .din_i(din),
      .clear_ovl_i(clr), .quantized_value_o(q_out), .pn_seq_o(pn_out),
      .q_valid_o(qv_out), .overload_o(ovl_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      me1 = 0; me2 = 0; mq = 0; mpn = 0; mvld = 0; movl = 0; mlfsr = 1;
   endtask

   task automatic model_update(input logic v, input int d, input logic c);
      int u, qr, fb;
      logic set;
      set = 1'b0;
      if (v) begin
         u = d + 2 * me1 - me2;
         qr = (u >= 0) ? u / 256 : -((-u + 255) / 256);
         if (qr > 15 || qr < 0) begin
            mq = (qr > 15) ? 15 : 0;
            me1 = 0; me2 = 0; set = 1'b1;
         end else begin
            mq = qr;
            me2 = me1;
            me1 = u - qr * 256;
         end
         fb = ((mlfsr >> 14) ^ (mlfsr >> 13)) & 1;
         mlfsr = ((mlfsr << 1) | fb) & 32'h7fff;
         mpn = fb;
      end
      mvld = v;
      movl = set ? 1 : (c ? 0 : movl);
   endtask

   task automatic check_all();
      check("code", q_out, mq);
      check("pn", pn_out, mpn);
      check("valid", qv_out, mvld);
      check("ovl", ovl_out, movl);
   endtask

   task automatic step(input logic v, input logic [11:0] d, input logic c);
      valid = v; din = d; clr = c;
      @(posedge clk);
      model_update(v, d, c);
      #1;
      check_all();
   endtask

   // reset lands mid-cycle with a sample on the input, which must be discarded
   task automatic apply_reset(input int cycles);
      valid = 1'b1; din = 12'hFFF; clr = 1'b0;
      #2 reset_n = 1'b0;
      model_reset();
      #1 check_all();
      repeat (cycles) @(posedge clk);
      #1 check_all();
      valid = 1'b0;
      reset_n = 1'b1;
      repeat (3) step(1'b0, 12'h000, 1'b0);
   endtask

   initial begin
      int k;
      model_reset();
      valid = 1'b1; din = 12'hFFF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_code", q_out, 0);
      check("rst_valid", qv_out, 0);
      check("rst_pn", pn_out, 0);
      check("rst_ovl", ovl_out, 0);
      valid = 1'b0;
      reset_n = 1'b1;
      repeat (3) step(1'b0, 12'h000, 1'b0);

      for (int i = 0; i < 20; i++) begin
         step(1'b1, 12'h800, 1'b0);
         check("mid_code", q_out, 8);
      end
      check("mid_ovl", ovl_out, 0);

      apply_reset(2);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 12'h880, 1'b0);
         check("ns_code", q_out, ((i % 4) == 1 || (i % 4) == 2) ? 9 : 8);
      end
      check("ns_ovl", ovl_out, 0);

      apply_reset(1);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 12'h880, 1'b0);
         check("gap_code", q_out, ((i % 4) == 1 || (i % 4) == 2) ? 9 : 8);
         step(1'b0, 12'h880, 1'b0);
         check("gap_hold", q_out, ((i % 4) == 1 || (i % 4) == 2) ? 9 : 8);
         check("gap_vld", qv_out, 0);
      end

      apply_reset(1);
      step(1'b1, 12'hFFF, 1'b0);
      check("ovl_q1", q_out, 15);
      check("ovl_f1", ovl_out, 0);
      step(1'b1, 12'hFFF, 1'b0);
      check("ovl_q2", q_out, 15);
      check("ovl_f2", ovl_out, 1);
      step(1'b1, 12'hFFF, 1'b1);
      check("ovl_clr", ovl_out, 0);
      step(1'b1, 12'hFFF, 1'b0);
      check("ovl_reset", ovl_out, 1);
      step(1'b1, 12'hFFF, 1'b0);
      step(1'b1, 12'hFFF, 1'b1);
      check("ovl_set_wins", ovl_out, 1);
      step(1'b0, 12'h000, 1'b0);
      check("ovl_sticky", ovl_out, 1);

      apply_reset(1);
      for (int s = 1; s <= 32767 + 64; s++) begin
         step(1'b1, 12'($urandom), 1'b0);
         if (s <= 14) check("pn_seed", pn_out, (s == 14) ? 1 : 0);
         if (s <= 64) hist[s-1] = pn_out;
         if (s > 32767) check("pn_period", pn_out, hist[s-32768]);
      end

      apply_reset(1);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(499) == 0) apply_reset($urandom_range(2));
         k = $urandom_range(3);
         step($urandom_range(3) != 0,
              (k == 0) ? 12'($urandom_range(63)) : (k == 1) ? 12'hFC0 | 12'($urandom_range(63)) : 12'($urandom),
              $urandom_range(15) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
